operand_fetch: RTL and testbench

//   Operand fetch stage: holds the architectural register file and supplies the

---
 rtl/operand_fetch.sv | 87 ++++++++
 tb/tb_operand_fetch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: architectural register file feeding a 1-deep valid/ready operand stage.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN (same-cycle writeback forwarding and
// refresh of a stalled bundle's operands).
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREGS = 16,
    parameter int OP_W = 4,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [OP_W-1:0]   in_op,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic [OP_W-1:0]   out_op
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              issue;
    logic              wr;
`ifdef OPERAND_FETCH_BYPASS_EN
    logic [ADDR_W-1:0] hold_rs1, hold_rs2;
`endif

    assign in_ready = !rst && (!out_valid || out_ready);
    assign issue = in_valid && in_ready;
    assign wr = wb_en && wb_addr != '0;

    // operand reads: r0 reads as zero; with bypass, a same-cycle write wins over the stored value
    always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
        rd_a = (in_rs1 == '0) ? '0 : (wr && wb_addr == in_rs1) ? wb_data : regs[in_rs1];
        rd_b = (in_rs2 == '0) ? '0 : (wr && wb_addr == in_rs2) ? wb_data : regs[in_rs2];
`else
        rd_a = (in_rs1 == '0) ? '0 : regs[in_rs1];
        rd_b = (in_rs2 == '0) ? '0 : regs[in_rs2];
`endif
    end

    // register file writeback and output bundle load/drain/hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            out_valid <= 1'b0;
            out_a <= '0;
            out_b <= '0;
            out_rd <= '0;
            out_op <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
            hold_rs1 <= '0;
            hold_rs2 <= '0;
`endif
        end else begin
            if (wr) regs[wb_addr] <= wb_data;
            if (issue) begin
                out_valid <= 1'b1;
                out_a <= rd_a;
                out_b <= rd_b;
                out_rd <= in_rd;
                out_op <= in_op;
`ifdef OPERAND_FETCH_BYPASS_EN
                hold_rs1 <= in_rs1;
                hold_rs2 <= in_rs2;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef OPERAND_FETCH_BYPASS_EN
            else if (out_valid && wr) begin
                if (wb_addr == hold_rs1) out_a <= wb_data;
                if (wb_addr == hold_rs2) out_b <= wb_data;
            end
`endif
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed + random stimulus against a behavioural model of operand_fetch.
module tb_operand_fetch;
`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, wb_en, out_valid, out_ready;
    logic [3:0] in_rs1, in_rs2, in_rd, in_op, wb_addr, out_rd, out_op;
    logic [31:0] wb_data, out_a, out_b;

    int total = 0;
    int passed = 0;

    logic [31:0] m_regs [16];
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_rd, m_op, m_rs1, m_rs2;

    operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_op(out_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] src(input logic [3:0] a);
        if (a == 0) return 32'h0;
        if (BYP && wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    // One clock: apply inputs, check in_ready, clock, update model, check outputs.
    task automatic cyc(input logic r, input logic iv, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [3:0] op, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd, input logic ordy);
        logic exp_ready, acc;
        rst = r; in_valid = iv; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_op = op;
        wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
        #1;
        exp_ready = !r && (!m_valid || ordy);
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
            m_valid = 0; m_a = 0; m_b = 0; m_rd = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0;
        end else begin
            acc = iv && exp_ready;
            if (acc) begin
                m_a = src(s1); m_b = src(s2); m_rd = d; m_op = op;
                m_rs1 = s1; m_rs2 = s2; m_valid = 1;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end else if (BYP && m_valid && we && wa != 0) begin
                if (wa == m_rs1) m_a = wd;
                if (wa == m_rs2) m_b = wd;
            end
            if (we && wa != 0) m_regs[wa] = wd;
        end
        #1;
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_rd", {28'h0, out_rd}, {28'h0, m_rd});
        chk("out_op", {28'h0, out_op}, {28'h0, m_op});
    endtask

    initial begin
        logic [31:0] snap_a, snap_b;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 3, 1, 1, 1, 3, 32'hDEAD, 1);
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_a", out_a, 32'h0);
        // write r3, then issue rs1=3 rs2=0
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 32'h12345678, 1);
        cyc(0, 1, 3, 0, 4'd9, 4'd2, 0, 0, 0, 1);
        chk("r3_a", out_a, 32'h12345678);
        chk("r3_b", out_b, 32'h0);
        chk("r3_valid", {31'h0, out_valid}, 32'h1);
        // r0 stays zero
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1);
        cyc(0, 1, 0, 0, 4'd1, 4'd3, 0, 0, 0, 1);
        chk("r0_a", out_a, 32'h0);
        // stall three cycles with a pending issue
        cyc(0, 1, 3, 3, 4'd5, 4'd7, 0, 0, 0, 0);
        snap_a = out_a; snap_b = out_b;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 4'd6, 4'd8, 0, 0, 0, 0);
            chk("stall_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_a", out_a, snap_a);
        end
        cyc(0, 1, 0, 3, 4'd6, 4'd8, 0, 0, 0, 1);
        chk("release_rd", {28'h0, out_rd}, 32'd6);
        chk("release_b", out_b, 32'h12345678);
        // same-cycle write and issue of r5
        cyc(0, 1, 5, 0, 0, 0, 1, 5, 32'hA5, 1);
        chk("fwd_a", out_a, BYP ? 32'hA5 : 32'h0);
        // stalled bundle with rs2=7, then write r7
        cyc(0, 1, 0, 7, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 32'h55, 0);
        chk("refresh_b", out_b, BYP ? 32'h55 : 32'h0);
        // reset while stalled
        cyc(0, 1, 3, 5, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 3, 5, 1, 1, 0, 0, 0, 0);
        chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        for (int i = 1; i < 16; i += 2) begin
            cyc(0, 1, i[3:0], 4'(i + 1), 0, 0, 0, 0, 0, 1);
            chk("rst_regs_a", out_a, 32'h0);
            chk("rst_regs_b", out_b, 32'h0);
        end
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), $urandom_range(0, 2) != 0, 4'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) != 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
